pifo_port_client: RTL and testbench
===================================

PIFO_PORT_CLIENT -- requirements
Module: pifo_port_client

Interface
REQ-001 SHALL have parameter PTW, default 16, payload width.
REQ-002 SHALL have parameter MTW, default 0, metadata width; DW = MTW+PTW.
REQ-003 SHALL have parameter TREE_NUM, default 4, virtual tree count; TB = $clog2(TREE_NUM).
REQ-004 SHALL have parameter RESP_DEPTH, default 4, power of two, response FIFO depth and pop credit limit.
REQ-005 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_arst_n  in  1  asynchronous, active-low reset.
- i_push_valid  in  1  push request.
- o_push_ready  out  1  push request accepted this cycle.
- i_push_tree_id  in  TB  target tree of push.
- i_push_data  in  DW  push value.
- i_pop_valid  in  1  pop request.
- o_pop_ready  out  1  pop request accepted this cycle.
- i_pop_tree_id  in  TB  target tree of pop.
- o_push  out  1  push strobe to the PIFO tree port.
- o_pop  out  1  pop strobe to the PIFO tree port.
- o_tree_id  out  TB  tree id for the issued strobe.
- o_push_data  out  DW  data for the issued push.
- i_task_fifo_full  in  1  full flag of this port's task FIFO.
- i_is_level0_pop  in  1  pop result present this cycle.
- i_rsp_tree_id  in  TB  tree id of the pop result.
- i_rsp_data  in  DW  pop result value.
- o_resp_valid  out  1  response FIFO non-empty.
- i_resp_ready  in  1  consumer takes head.
- o_resp_tree_id  out  TB  head tree id.
- o_resp_data  out  DW  head data.
- o_resp_null  out  1  head data all ones (popped tree empty).
- o_outstanding  out  $clog2(RESP_DEPTH)+1  issued pops not yet returned.
- o_err_unexpected  out  1  sticky: result arrived with nothing outstanding.

Function
REQ-006 Push eligible = i_push_valid & !i_task_fifo_full.
REQ-007 Pop eligible = i_pop_valid & !i_task_fifo_full & (o_outstanding + response FIFO count < RESP_DEPTH).
REQ-008 At most one of o_push_ready/o_pop_ready SHALL be high per cycle; o_push and o_pop SHALL never be high together (the task FIFO discards simultaneous push+pop).
REQ-009 Single eligible requester granted; both eligible -> round-robin via last_grant register, grant the one not granted last; last_grant updates on each accept.
REQ-010 Ready signals combinational from eligibility and arbitration; valid/data may be sampled only when ready is high.
REQ-011 Accept in cycle N -> o_push or o_pop high in cycle N+1 for exactly one cycle, o_tree_id/o_push_data registered from accepted request; idle cycles drive o_push=o_pop=0, o_tree_id=0, o_push_data all ones.
REQ-012 Issue rate SHALL be at most one strobe per cycle; back-to-back accepts allowed.
REQ-013 o_outstanding +1 on pop accept, -1 on i_is_level0_pop; both same cycle -> unchanged.
REQ-014 i_is_level0_pop with o_outstanding==0 and no same-cycle pop accept -> result dropped, counter stays 0, o_err_unexpected set until reset.
REQ-015 Valid result writes {i_rsp_tree_id, i_rsp_data} into response FIFO same edge; first-word-fall-through, o_resp_valid = count!=0.
REQ-016 Pop on o_resp_valid & i_resp_ready; simultaneous write and pop allowed at any count including full; credit rule REQ-007 guarantees no overflow.
REQ-017 Pointers wrap modulo RESP_DEPTH; count width $clog2(RESP_DEPTH)+1.
REQ-018 o_resp_null = (o_resp_data == all ones), qualified by o_resp_valid.

Reset
REQ-019 Reset asserted asynchronously clears pointers, count, o_outstanding, o_err_unexpected, strobes, o_tree_id; o_push_data and o_resp_data read all ones; last_grant = pop so push wins first tie.
REQ-020 Reset mid-operation discards in-flight strobes and buffered responses; late results after reset follow REQ-014.

Verification
REQ-021 Push and pop valid simultaneously for 4 cycles, full low -> grants push, pop, push, pop; never both strobes high.
REQ-022 Push tree 2 data 0x0123 accepted cycle N -> o_push=1, o_tree_id=2, o_push_data=0x0123 at N+1 only.
REQ-023 i_task_fifo_full=1 with both valid -> both readies 0, no strobes; full drops -> issue next cycle.
REQ-024 RESP_DEPTH=4, 4 pops issued, no results, i_resp_ready=0 -> 5th pop blocked, o_outstanding=4; one result returns -> still blocked (count 1 + 3 = 4) until consumer pops.
REQ-025 Result data 0xFFFF tree 1 -> o_resp_valid=1, o_resp_null=1, o_resp_tree_id=1; result with o_outstanding=0 -> o_err_unexpected=1, FIFO unchanged.
REQ-026 Reset pulse with 2 responses buffered and 1 outstanding -> o_resp_valid=0, o_outstanding=0 immediately, without clock edge.

Source files
------------

// File: rtl/pifo_port_client_if.sv
// pifo_port_client_if: request, tree-port and response signals of one PIFO port client.
interface pifo_port_client_if #(
    parameter int PTW        = 16,
    parameter int MTW        = 0,
    parameter int TREE_NUM   = 4,
    parameter int RESP_DEPTH = 4
);
    localparam int DW = MTW + PTW;
    localparam int TB = $clog2(TREE_NUM);
    localparam int CW = $clog2(RESP_DEPTH) + 1;
    logic          push_valid, push_ready;
    logic [TB-1:0] push_tree_id;
    logic [DW-1:0] push_data;
    logic          pop_valid, pop_ready;
    logic [TB-1:0] pop_tree_id;
    logic          push, pop;
    logic [TB-1:0] tree_id;
    logic [DW-1:0] tree_push_data;
    logic          task_fifo_full, is_level0_pop;
    logic [TB-1:0] rsp_tree_id;
    logic [DW-1:0] rsp_data;
    logic          resp_valid, resp_ready, resp_null;
    logic [TB-1:0] resp_tree_id;
    logic [DW-1:0] resp_data;
    logic [CW-1:0] outstanding;
    logic          err_unexpected;
    modport slave (
        input  push_valid, push_tree_id, push_data, pop_valid, pop_tree_id,
               task_fifo_full, is_level0_pop, rsp_tree_id, rsp_data, resp_ready,
        output push_ready, pop_ready, push, pop, tree_id, tree_push_data,
               resp_valid, resp_tree_id, resp_data, resp_null, outstanding, err_unexpected
    );
    modport master (
        output push_valid, push_tree_id, push_data, pop_valid, pop_tree_id,
               task_fifo_full, is_level0_pop, rsp_tree_id, rsp_data, resp_ready,
        input  push_ready, pop_ready, push, pop, tree_id, tree_push_data,
               resp_valid, resp_tree_id, resp_data, resp_null, outstanding, err_unexpected
    );
endinterface

// File: rtl/pifo_port_client.sv
// pifo_port_client: arbitrates push/pop requests onto one PIFO tree port and buffers pop results.
module pifo_port_client #(
    parameter int PTW        = 16,
    parameter int MTW        = 0,
    parameter int TREE_NUM   = 4,
    parameter int RESP_DEPTH = 4
) (
    input logic i_clk,
    input logic i_arst_n,
    pifo_port_client_if.slave b
);
    localparam int DW = MTW + PTW;
    localparam int TB = $clog2(TREE_NUM);
    localparam int AW = $clog2(RESP_DEPTH);
    localparam int CW = AW + 1;
    logic              last_pop;
    logic [CW-1:0]     outstanding, count;
    logic [AW-1:0]     wptr, rptr;
    logic [TB+DW-1:0]  mem [RESP_DEPTH];
    logic              push_elig, pop_elig, rsp_ok, rd;
    assign push_elig = b.push_valid & ~b.task_fifo_full;
    // Credits cover both in-flight pops and buffered results so the FIFO can never overflow.
    assign pop_elig = b.pop_valid & ~b.task_fifo_full &
                      (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(RESP_DEPTH));
    assign b.push_ready = push_elig & (~pop_elig | last_pop);
    assign b.pop_ready = pop_elig & (~push_elig | ~last_pop);
    assign rsp_ok = b.is_level0_pop & ((outstanding != '0) | b.pop_ready);
    assign rd = b.resp_valid & b.resp_ready;
    assign b.resp_valid = count != '0;
    assign b.resp_tree_id = b.resp_valid ? mem[rptr][TB+DW-1:DW] : '0;
    assign b.resp_data = b.resp_valid ? mem[rptr][DW-1:0] : '1;
    assign b.resp_null = b.resp_valid & (&b.resp_data);
    assign b.outstanding = outstanding;
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            last_pop         <= 1'b1;
            outstanding      <= '0;
            count            <= '0;
            wptr             <= '0;
            rptr             <= '0;
            b.push           <= 1'b0;
            b.pop            <= 1'b0;
            b.tree_id        <= '0;
            b.tree_push_data <= '1;
            b.err_unexpected <= 1'b0;
        end else begin
            b.push           <= b.push_ready;
            b.pop            <= b.pop_ready;
            b.tree_id        <= b.push_ready ? b.push_tree_id : b.pop_ready ? b.pop_tree_id : '0;
            b.tree_push_data <= b.push_ready ? b.push_data : '1;
            if (b.push_ready | b.pop_ready) last_pop <= b.pop_ready;
            outstanding <= outstanding + CW'(b.pop_ready) - CW'(rsp_ok);
            if (b.is_level0_pop & ~rsp_ok) b.err_unexpected <= 1'b1;
            if (rsp_ok) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            count <= count + CW'(rsp_ok) - CW'(rd);
        end
    end
    always_ff @(posedge i_clk) begin
        if (rsp_ok) mem[wptr] <= {b.rsp_tree_id, b.rsp_data};
    end
endmodule

// File: tb/tb_pifo_port_client.sv
// tb_pifo_port_client: directed scenarios plus a randomized run against a queue-based model.
module tb_pifo_port_client;
    localparam int RD = 4;
    logic i_clk = 1'b0;
    logic i_arst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    pifo_port_client_if #(.PTW(16), .MTW(0), .TREE_NUM(4), .RESP_DEPTH(RD)) bus ();
    pifo_port_client #(.PTW(16), .MTW(0), .TREE_NUM(4), .RESP_DEPTH(RD)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .b(bus)
    );
    always #5 i_clk = ~i_clk;

    task automatic idle();
        bus.push_valid = 0; bus.push_tree_id = 0; bus.push_data = 0;
        bus.pop_valid = 0; bus.pop_tree_id = 0; bus.task_fifo_full = 0;
        bus.is_level0_pop = 0; bus.rsp_tree_id = 0; bus.rsp_data = 0; bus.resp_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        i_arst_n = 0;
        #3 i_arst_n = 1;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus.push, bus.pop, bus.tree_id, bus.tree_push_data} !== {1'b0, 1'b0, 2'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset_strobes got %h exp %h", {bus.push, bus.pop, bus.tree_id, bus.tree_push_data}, {4'd0, 16'hFFFF});
        end
        checks++;
        if ({bus.resp_valid, bus.resp_data, bus.outstanding, bus.err_unexpected} !== {1'b1 ^ 1'b1, 16'hFFFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_resp got %h exp %h", {bus.resp_valid, bus.resp_data, bus.outstanding, bus.err_unexpected}, {1'b0, 16'hFFFF, 4'd0});
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        bus.push_valid = 1; bus.pop_valid = 1; bus.push_tree_id = 1; bus.pop_tree_id = 3; bus.push_data = 16'h00AA;
        for (int i = 0; i < 4; i++) begin
            logic ep;
            ep = (i % 2 == 0);
            #1;
            checks++;
            if ({bus.push_ready, bus.pop_ready} !== {ep, !ep}) begin
                errors++;
                $display("FAIL arb_ready cyc%0d got %b exp %b", i, {bus.push_ready, bus.pop_ready}, {ep, !ep});
            end
            @(posedge i_clk); #1;
            checks++;
            if ({bus.push, bus.pop, bus.tree_id} !== {ep, !ep, ep ? 2'd1 : 2'd3}) begin
                errors++;
                $display("FAIL arb_strobe cyc%0d got %b exp %b", i, {bus.push, bus.pop, bus.tree_id}, {ep, !ep, ep ? 2'd1 : 2'd3});
            end
            @(negedge i_clk);
        end
        idle();
    endtask

    task automatic test_push_issue();
        do_reset();
        bus.push_valid = 1; bus.push_tree_id = 2; bus.push_data = 16'h0123;
        #1;
        checks++;
        if (bus.push_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready got %b exp 1", bus.push_ready);
        end
        @(posedge i_clk); #1;
        checks++;
        if ({bus.push, bus.pop, bus.tree_id, bus.tree_push_data} !== {1'b1, 1'b0, 2'd2, 16'h0123}) begin
            errors++;
            $display("FAIL push_issue got %h exp %h", {bus.push, bus.pop, bus.tree_id, bus.tree_push_data}, {4'b1010, 16'h0123});
        end
        @(negedge i_clk);
        idle();
        @(posedge i_clk); #1;
        checks++;
        if ({bus.push, bus.pop, bus.tree_id, bus.tree_push_data} !== {1'b0, 1'b0, 2'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL push_idle got %h exp %h", {bus.push, bus.pop, bus.tree_id, bus.tree_push_data}, {4'd0, 16'hFFFF});
        end
        @(negedge i_clk);
    endtask

    task automatic test_full();
        do_reset();
        bus.task_fifo_full = 1; bus.push_valid = 1; bus.pop_valid = 1;
        #1;
        checks++;
        if ({bus.push_ready, bus.pop_ready} !== 2'b00) begin
            errors++;
            $display("FAIL full_ready got %b exp 00", {bus.push_ready, bus.pop_ready});
        end
        @(posedge i_clk); #1;
        checks++;
        if ({bus.push, bus.pop} !== 2'b00) begin
            errors++;
            $display("FAIL full_strobe got %b exp 00", {bus.push, bus.pop});
        end
        @(negedge i_clk);
        bus.task_fifo_full = 0;
        #1;
        checks++;
        if ({bus.push_ready, bus.pop_ready} !== 2'b10) begin
            errors++;
            $display("FAIL unfull_ready got %b exp 10", {bus.push_ready, bus.pop_ready});
        end
        @(posedge i_clk); #1;
        checks++;
        if ({bus.push, bus.pop} !== 2'b10) begin
            errors++;
            $display("FAIL unfull_strobe got %b exp 10", {bus.push, bus.pop});
        end
        @(negedge i_clk);
        idle();
    endtask

    task automatic test_credit();
        do_reset();
        bus.pop_valid = 1; bus.pop_tree_id = 1;
        for (int i = 0; i < RD; i++) begin
            #1;
            checks++;
            if (bus.pop_ready !== 1'b1) begin
                errors++;
                $display("FAIL credit_accept pop%0d got %b exp 1", i, bus.pop_ready);
            end
            @(negedge i_clk);
        end
        #1;
        checks++;
        if ({bus.pop_ready, bus.outstanding} !== {1'b0, 3'd4}) begin
            errors++;
            $display("FAIL credit_block got %b exp %b", {bus.pop_ready, bus.outstanding}, {1'b0, 3'd4});
        end
        bus.is_level0_pop = 1; bus.rsp_tree_id = 1; bus.rsp_data = 16'hFFFF;
        @(negedge i_clk);
        bus.is_level0_pop = 0;
        #1;
        checks++;
        if ({bus.pop_ready, bus.resp_valid, bus.resp_null, bus.resp_tree_id, bus.outstanding} !== {3'b011, 2'd1, 3'd3}) begin
            errors++;
            $display("FAIL credit_result got %b exp %b", {bus.pop_ready, bus.resp_valid, bus.resp_null, bus.resp_tree_id, bus.outstanding}, {3'b011, 2'd1, 3'd3});
        end
        bus.resp_ready = 1;
        @(posedge i_clk); #1;
        checks++;
        if ({bus.pop_ready, bus.resp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL credit_release got %b exp 10", {bus.pop_ready, bus.resp_valid});
        end
        @(negedge i_clk);
        idle();
    endtask

    task automatic test_unexpected();
        do_reset();
        bus.is_level0_pop = 1; bus.rsp_tree_id = 2; bus.rsp_data = 16'h1234;
        @(posedge i_clk); #1;
        checks++;
        if ({bus.err_unexpected, bus.resp_valid, bus.outstanding} !== {2'b10, 3'd0}) begin
            errors++;
            $display("FAIL unexpected got %b exp %b", {bus.err_unexpected, bus.resp_valid, bus.outstanding}, {2'b10, 3'd0});
        end
        @(negedge i_clk);
        idle();
        @(posedge i_clk); #1;
        checks++;
        if (bus.err_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", bus.err_unexpected);
        end
        @(negedge i_clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.pop_valid = 1;
        repeat (3) @(negedge i_clk);
        bus.pop_valid = 0; bus.is_level0_pop = 1; bus.rsp_data = 16'h0005;
        repeat (2) @(negedge i_clk);
        bus.is_level0_pop = 0;
        #1;
        checks++;
        if ({bus.resp_valid, bus.outstanding} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL areset_pre got %b exp %b", {bus.resp_valid, bus.outstanding}, {1'b1, 3'd1});
        end
        #1 i_arst_n = 0;
        #1;
        checks++;
        if ({bus.resp_valid, bus.outstanding} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL areset_now got %b exp %b", {bus.resp_valid, bus.outstanding}, 4'd0);
        end
        i_arst_n = 1;
        @(negedge i_clk);
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        bit lg_pop = 1, err = 0, e_push = 0, e_pop = 0;
        int outst = 0;
        logic [1:0] e_tid = 0;
        logic [15:0] e_dat = 16'hFFFF;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit pe, oe, pr, orr, vld;
            logic [17:0] head;
            bus.push_valid = 1'($urandom); bus.pop_valid = 1'($urandom);
            bus.task_fifo_full = ($urandom % 5 == 0);
            bus.push_tree_id = 2'($urandom); bus.pop_tree_id = 2'($urandom);
            bus.push_data = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
            bus.resp_ready = ($urandom % 3 != 0);
            bus.is_level0_pop = (outst > 0) ? 1'($urandom) : ($urandom % 20 == 0);
            bus.rsp_tree_id = 2'($urandom);
            bus.rsp_data = ($urandom % 6 == 0) ? 16'hFFFF : 16'($urandom);
            #1;
            pe = bus.push_valid && !bus.task_fifo_full;
            oe = bus.pop_valid && !bus.task_fifo_full && (outst + q.size() < RD);
            pr = pe && (!oe || lg_pop);
            orr = oe && (!pe || !lg_pop);
            head = (q.size() > 0) ? q[0] : {2'd0, 16'hFFFF};
            checks++;
            if ({bus.push_ready, bus.pop_ready} !== {pr, orr}) begin
                errors++;
                $display("FAIL rnd_ready c%0d got %b exp %b", c, {bus.push_ready, bus.pop_ready}, {pr, orr});
            end
            checks++;
            if ({bus.push, bus.pop, bus.tree_id, bus.tree_push_data} !== {e_push, e_pop, e_tid, e_dat}) begin
                errors++;
                $display("FAIL rnd_strobe c%0d got %h exp %h", c, {bus.push, bus.pop, bus.tree_id, bus.tree_push_data}, {e_push, e_pop, e_tid, e_dat});
            end
            checks++;
            if ({bus.resp_valid, bus.resp_tree_id, bus.resp_data, bus.resp_null} !== {q.size() > 0, head, q.size() > 0 && head[15:0] == 16'hFFFF}) begin
                errors++;
                $display("FAIL rnd_resp c%0d got %h exp %h", c, {bus.resp_valid, bus.resp_tree_id, bus.resp_data, bus.resp_null}, {q.size() > 0, head, q.size() > 0 && head[15:0] == 16'hFFFF});
            end
            checks++;
            if ({bus.outstanding, bus.err_unexpected} !== {3'(outst), err}) begin
                errors++;
                $display("FAIL rnd_count c%0d got %b exp %b", c, {bus.outstanding, bus.err_unexpected}, {3'(outst), err});
            end
            e_push = pr; e_pop = orr;
            e_tid = pr ? bus.push_tree_id : orr ? bus.pop_tree_id : 2'd0;
            e_dat = pr ? bus.push_data : 16'hFFFF;
            if (pr) lg_pop = 0; else if (orr) lg_pop = 1;
            if (q.size() > 0 && bus.resp_ready) void'(q.pop_front());
            vld = bus.is_level0_pop && (outst > 0 || orr);
            if (vld) begin
                q.push_back({bus.rsp_tree_id, bus.rsp_data});
                outst--;
            end else if (bus.is_level0_pop) err = 1;
            if (orr) outst++;
            @(negedge i_clk);
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge i_clk);
        test_reset();
        test_arbitration();
        test_push_issue();
        test_full();
        test_credit();
        test_unexpected();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
